// File: rtl/rptr_pkg.sv
// rptr_pkg: Gray/binary helpers and default pointer type for the read-pointer block
// Functions work on 32-bit vectors; callers cast to their AWIDTH+1 pointer width.
package rptr_pkg;
  localparam int PTR_W = 4;
  typedef logic [PTR_W-1:0] ptr_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_comb.sv
// gray2bin_comb: combinational Gray to binary conversion of width W
// Ports: i_gray [W-1:0] Gray input, o_bin [W-1:0] binary output.
module gray2bin_comb #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end
endmodule

// File: rtl/rptr_rempty_lvl.sv
// rptr_rempty_lvl: async-FIFO read pointer, Gray pointer, empty/almost-empty flags and fill level
// Ports: rclk, rrst (async, active-high), rinc (pop request), rwptr_gray (synchronised write ptr),
//        raddr (RAM read address), rptr (Gray read ptr), rempty, ralmost_empty, rlevel,
//        runderflow / runderflow_clr present only when RPTR_UNDERFLOW_EN is defined.
module rptr_rempty_lvl
  import rptr_pkg::*;
#(
  parameter int AWIDTH   = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              rinc,
  input  logic [AWIDTH:0]   rwptr_gray,
  output logic [AWIDTH-1:0] raddr,
  output logic [AWIDTH:0]   rptr,
  output logic              rempty,
  output logic              ralmost_empty,
`ifdef RPTR_UNDERFLOW_EN
  output logic [AWIDTH:0]   rlevel,
  output logic              runderflow,
  input  logic              runderflow_clr
`else
  output logic [AWIDTH:0]   rlevel
`endif
);
  logic [AWIDTH:0] r_bin, w_bnext, w_gnext, w_wbin, w_lvl_next;
  logic            w_rd_en;
  gray2bin_comb #(.W(AWIDTH + 1)) u_g2b (.i_gray(rwptr_gray), .o_bin(w_wbin));
  assign w_rd_en    = rinc & ~rempty;
  assign w_bnext    = r_bin + {{AWIDTH{1'b0}}, w_rd_en};
  assign w_gnext    = (AWIDTH + 1)'(bin2gray(32'(w_bnext)));
  // Modulo subtraction yields 0 .. 2**AWIDTH since the MSB disambiguates full from empty
  assign w_lvl_next = w_wbin - w_bnext;
  assign raddr      = r_bin[AWIDTH-1:0];
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_bin         <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      r_bin         <= w_bnext;
      rptr          <= w_gnext;
      rempty        <= w_gnext == rwptr_gray;
      ralmost_empty <= w_lvl_next <= (AWIDTH + 1)'(AE_LEVEL);
      rlevel        <= w_lvl_next;
    end
  end
`ifdef RPTR_UNDERFLOW_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) runderflow <= 1'b0;
    else runderflow <= (rinc & rempty) | (runderflow & ~runderflow_clr);
  end
`endif
endmodule

// File: tb/tb_rptr_rempty_lvl.sv
// tb_rptr_rempty_lvl: directed scoreboard bench for rptr_rempty_lvl (AWIDTH=3, AE_LEVEL=1)
module tb_rptr_rempty_lvl;
  typedef struct packed {
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       empty;
    logic       ae;
    logic [3:0] lvl;
    logic       uf;
  } exp_t;
  logic       clk = 0, rst = 1, inc = 0, clr = 0;
  logic [3:0] wg = '0;
  logic [2:0] raddr;
  logic [3:0] rptr, rlevel;
  logic       rempty, ralmost_empty;
  logic       uf_act;
  exp_t       q[$];
  int         n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
`ifdef RPTR_UNDERFLOW_EN
  rptr_rempty_lvl #(.AWIDTH(3), .AE_LEVEL(1)) dut (
    .rclk(clk), .rrst(rst), .rinc(inc), .rwptr_gray(wg), .raddr(raddr), .rptr(rptr),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel),
    .runderflow(uf_act), .runderflow_clr(clr));
`else
  assign uf_act = 1'b0;
  rptr_rempty_lvl #(.AWIDTH(3), .AE_LEVEL(1)) dut (
    .rclk(clk), .rrst(rst), .rinc(inc), .rwptr_gray(wg), .raddr(raddr), .rptr(rptr),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel));
`endif
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({raddr, rptr, rempty, ralmost_empty, rlevel} !== {e.raddr, e.rptr, e.empty, e.ae, e.lvl}) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got raddr=%0d rptr=%b empty=%b ae=%b lvl=%0d, want raddr=%0d rptr=%b empty=%b ae=%b lvl=%0d",
                 $time, raddr, rptr, rempty, ralmost_empty, rlevel, e.raddr, e.rptr, e.empty, e.ae, e.lvl);
      end
`ifdef RPTR_UNDERFLOW_EN
      n_cmp++;
      if (uf_act !== e.uf) begin
        n_bad++;
        $display("FAIL underflow t=%0t: got %b want %b", $time, uf_act, e.uf);
      end
`endif
    end
  end
  task automatic step(input logic r, input logic i, input logic c, input logic [3:0] g,
                      input logic [2:0] ea, input logic [3:0] ep, input logic ee,
                      input logic eae, input logic [3:0] el, input logic eu);
    @(negedge clk);
    rst = r; inc = i; clr = c; wg = g;
    q.push_back('{ea, ep, ee, eae, el, eu});
  endtask
  initial begin
    step(1, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    step(1, 1, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    step(0, 1, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 1);
    step(0, 0, 1, 4'b0010, 0, 4'b0000, 0, 0, 3, 0);
    step(0, 1, 0, 4'b0010, 1, 4'b0001, 0, 0, 2, 0);
    step(0, 1, 0, 4'b0010, 2, 4'b0011, 0, 1, 1, 0);
    step(0, 1, 0, 4'b0010, 3, 4'b0010, 1, 1, 0, 0);
    step(0, 1, 0, 4'b0010, 3, 4'b0010, 1, 1, 0, 1);
    step(0, 1, 0, 4'b0010, 3, 4'b0010, 1, 1, 0, 1);
    step(0, 1, 1, 4'b0010, 3, 4'b0010, 1, 1, 0, 1);
    step(0, 0, 1, 4'b1110, 3, 4'b0010, 0, 0, 8, 0);
    step(0, 1, 0, 4'b1010, 4, 4'b0110, 0, 0, 8, 0);
    step(0, 1, 0, 4'b1010, 5, 4'b0111, 0, 0, 7, 0);
    step(0, 1, 0, 4'b1010, 6, 4'b0101, 0, 0, 6, 0);
    step(0, 1, 0, 4'b1010, 7, 4'b0100, 0, 0, 5, 0);
    step(0, 1, 0, 4'b1010, 0, 4'b1100, 0, 0, 4, 0);
    step(0, 1, 0, 4'b1010, 1, 4'b1101, 0, 0, 3, 0);
    step(0, 1, 0, 4'b1010, 2, 4'b1111, 0, 0, 2, 0);
    step(0, 1, 0, 4'b1010, 3, 4'b1110, 0, 1, 1, 0);
    step(0, 1, 0, 4'b1010, 4, 4'b1010, 1, 1, 0, 0);
    step(0, 0, 0, 4'b0110, 4, 4'b1010, 0, 0, 8, 0);
    step(0, 1, 0, 4'b0110, 5, 4'b1011, 0, 0, 7, 0);
    step(0, 1, 0, 4'b0110, 6, 4'b1001, 0, 0, 6, 0);
    step(0, 1, 0, 4'b0110, 7, 4'b1000, 0, 0, 5, 0);
    step(1, 1, 0, 4'b0110, 0, 4'b0000, 1, 1, 0, 0);
    step(0, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0);
    step(0, 1, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 1);
    step(0, 1, 0, 4'b0001, 1, 4'b0001, 1, 1, 0, 1);
    @(negedge clk);
    inc = 0;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
